// File: rtl/ixu_mc_issue_queue.sv
// Issue queue feeding the IXU multi-cycle pipe.
// Entries live in an age-ordered array that compacts on issue: entry 0 is the
// oldest and the occupied entries are always 0..count-1. The oldest entry with
// both sources ready is issued each cycle. After a divide issues, the queue
// stops issuing until the divider drops busy.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_ISSUE     | normal operation, oldest ready entry may issue every cycle
// ST_WAIT_DIV  | divider owns the pipe; no issue until the first !busy_i cycle
module ixu_mc_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int NUM_WAKEUP = 4
) (
    input  logic                        core_clock_i,
    input  logic                        core_reset_i,
    input  logic                        core_flush_i,
    input  logic                        enq_valid_i,
    output logic                        enq_ready_o,
    input  logic [5:0]                  enq_rob_i,
    input  logic [5:0]                  enq_rs1_i,
    input  logic [5:0]                  enq_rs2_i,
    input  logic                        enq_rs1_rdy_i,
    input  logic                        enq_rs2_rdy_i,
    input  logic                        enq_div_i,
    input  logic [6*NUM_WAKEUP-1:0]     wakeup_dest_i,
    input  logic [NUM_WAKEUP-1:0]       wakeup_valid_i,
    output logic                        valid_o,
    output logic [17:0]                 data_o,
    input  logic                        busy_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic {
        ST_ISSUE    = 1'b0,
        ST_WAIT_DIV = 1'b1
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [5:0] rob;
        logic [5:0] rs1;
        logic       rs1_rdy;
        logic [5:0] rs2;
        logic       rs2_rdy;
        logic       div;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    entry_t          woken [DEPTH];
    entry_t          enq_ent;

    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   enq_pos;
    state_t          state_q;
    state_t          state_d;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic            issue;
    logic            enq_fire;

    // Tag 0 is the hardwired-ready register, so it never produces a hit.
    function automatic logic wake_hit(
        input logic [5:0]              tag,
        input logic [6*NUM_WAKEUP-1:0] dest,
        input logic [NUM_WAKEUP-1:0]   vld
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (vld[k] && (dest[6*k +: 6] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit && (tag != 6'd0);
    endfunction

    // Oldest ready entry: scan from the top so the lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].vld && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Issue depends only on registered state, never on busy_i.
    assign issue       = sel_found && (state_q == ST_ISSUE);
    assign valid_o     = issue;
    assign data_o      = issue ? {ent_q[sel_idx].rs2, ent_q[sel_idx].rs1, ent_q[sel_idx].rob}
                               : 18'd0;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign enq_ready_o = !full_o;
    assign enq_fire    = enq_valid_i && enq_ready_o;

    // Wakeup snoop applied to the stored entries; takes effect next cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]         = ent_q[i];
            woken[i].rs1_rdy = ent_q[i].rs1_rdy
                             | wake_hit(ent_q[i].rs1, wakeup_dest_i, wakeup_valid_i);
            woken[i].rs2_rdy = ent_q[i].rs2_rdy
                             | wake_hit(ent_q[i].rs2, wakeup_dest_i, wakeup_valid_i);
        end
    end

    // Incoming micro-op, with the same wakeup snoop so a coincident wakeup is kept.
    always_comb begin
        enq_ent         = '0;
        enq_ent.vld     = 1'b1;
        enq_ent.rob     = enq_rob_i;
        enq_ent.rs1     = enq_rs1_i;
        enq_ent.rs2     = enq_rs2_i;
        enq_ent.div     = enq_div_i;
        enq_ent.rs1_rdy = enq_rs1_rdy_i || (enq_rs1_i == 6'd0)
                        || wake_hit(enq_rs1_i, wakeup_dest_i, wakeup_valid_i);
        enq_ent.rs2_rdy = enq_rs2_rdy_i || (enq_rs2_i == 6'd0)
                        || wake_hit(enq_rs2_i, wakeup_dest_i, wakeup_valid_i);
    end

    // Next array contents: compact over the issued slot, then append at the tail.
    always_comb begin
        enq_pos = issue ? (count_q - CW'(1)) : count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woken[i];
        end
        if (issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_d[i] = woken[i+1];
                end
            end
            ent_d[DEPTH-1] = '0;
        end
        // enq_fire implies count_q < DEPTH, so enq_pos always lands inside the array.
        if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == enq_pos) begin
                    ent_d[i] = enq_ent;
                end
            end
        end
        count_d = count_q + CW'(enq_fire) - CW'(issue);
        if (core_flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            count_d = '0;
        end
    end

    // Entry storage and occupancy count.
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
        end
    end

    // Divide serialisation: next-state logic. busy_i is only looked at in
    // ST_WAIT_DIV; in ST_ISSUE it reflects the pipe accepting the divide itself.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ISSUE: begin
                if (issue && ent_q[sel_idx].div) begin
                    state_d = ST_WAIT_DIV;
                end
            end
            ST_WAIT_DIV: begin
                if (!busy_i) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
        if (core_flush_i) begin
            state_d = ST_ISSUE;
        end
    end

    // Divide serialisation: state register.
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            state_q <= ST_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_ixu_mc_issue_queue.sv
// Bench for ixu_mc_issue_queue: directed scenarios plus a randomized run,
// each checked against a queue-level model of the issue rules.
module tb_ixu_mc_issue_queue;

    localparam int DEPTH = 8;
    localparam int NW    = 4;

    logic              core_clock_i;
    logic              core_reset_i;
    logic              core_flush_i;
    logic              enq_valid_i;
    logic              enq_ready_o;
    logic [5:0]        enq_rob_i;
    logic [5:0]        enq_rs1_i;
    logic [5:0]        enq_rs2_i;
    logic              enq_rs1_rdy_i;
    logic              enq_rs2_rdy_i;
    logic              enq_div_i;
    logic [6*NW-1:0]   wakeup_dest_i;
    logic [NW-1:0]     wakeup_valid_i;
    logic              valid_o;
    logic [17:0]       data_o;
    logic              busy_i;
    logic              full_o;
    logic              empty_o;
    logic [3:0]        count_o;

    int checks;
    int failures;

    ixu_mc_issue_queue #(.DEPTH(DEPTH), .NUM_WAKEUP(NW)) dut (
        .core_clock_i   (core_clock_i),
        .core_reset_i   (core_reset_i),
        .core_flush_i   (core_flush_i),
        .enq_valid_i    (enq_valid_i),
        .enq_ready_o    (enq_ready_o),
        .enq_rob_i      (enq_rob_i),
        .enq_rs1_i      (enq_rs1_i),
        .enq_rs2_i      (enq_rs2_i),
        .enq_rs1_rdy_i  (enq_rs1_rdy_i),
        .enq_rs2_rdy_i  (enq_rs2_rdy_i),
        .enq_div_i      (enq_div_i),
        .wakeup_dest_i  (wakeup_dest_i),
        .wakeup_valid_i (wakeup_valid_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .busy_i         (busy_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o)
    );

    initial core_clock_i = 1'b0;
    always #5 core_clock_i = ~core_clock_i;

    // Reference model: list of micro-ops in age order plus a "divider owns pipe" flag.
    typedef struct {
        logic [5:0] rob;
        logic [5:0] rs1;
        logic [5:0] rs2;
        bit         r1;
        bit         r2;
        bit         dv;
    } m_ent_t;

    m_ent_t      mq[$];
    bit          m_div;
    bit          exp_valid;
    logic [17:0] exp_data;

    function automatic bit m_hit(input logic [5:0] tag);
        bit h;
        h = 0;
        for (int k = 0; k < NW; k++)
            if (wakeup_valid_i[k] && wakeup_dest_i[6*k +: 6] == tag) h = 1;
        return h && (tag != 0);
    endfunction

    task automatic model_outs();
        exp_valid = 0;
        exp_data  = '0;
        if (!m_div) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].r1 && mq[i].r2) begin
                    exp_valid = 1;
                    exp_data  = {mq[i].rs2, mq[i].rs1, mq[i].rob};
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        int     n0;
        m_ent_t e;
        model_outs();
        n0 = mq.size();
        if (core_flush_i) begin
            mq.delete();
            m_div = 0;
            return;
        end
        if (exp_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].r1 && mq[i].r2) begin
                    if (mq[i].dv) m_div = 1;
                    mq.delete(i);
                    break;
                end
            end
        end else if (m_div && !busy_i) begin
            m_div = 0;
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (m_hit(mq[i].rs1)) mq[i].r1 = 1;
            if (m_hit(mq[i].rs2)) mq[i].r2 = 1;
        end
        if (enq_valid_i && n0 < DEPTH) begin
            e.rob = enq_rob_i;
            e.rs1 = enq_rs1_i;
            e.rs2 = enq_rs2_i;
            e.r1  = enq_rs1_rdy_i || enq_rs1_i == 0 || m_hit(enq_rs1_i);
            e.r2  = enq_rs2_rdy_i || enq_rs2_i == 0 || m_hit(enq_rs2_i);
            e.dv  = enq_div_i;
            mq.push_back(e);
        end
    endtask

    // Advance one clock: model consumes the current inputs, then the DUT edge.
    task automatic tick();
        model_step();
        @(posedge core_clock_i);
        #1;
    endtask

    task automatic clear_inputs();
        core_flush_i   = 0;
        enq_valid_i    = 0;
        enq_rob_i      = 0;
        enq_rs1_i      = 0;
        enq_rs2_i      = 0;
        enq_rs1_rdy_i  = 0;
        enq_rs2_rdy_i  = 0;
        enq_div_i      = 0;
        wakeup_dest_i  = '0;
        wakeup_valid_i = '0;
    endtask

    task automatic set_enq(input logic [5:0] rob, input logic [5:0] rs1, input bit r1,
                           input logic [5:0] rs2, input bit r2, input bit dv);
        enq_valid_i   = 1;
        enq_rob_i     = rob;
        enq_rs1_i     = rs1;
        enq_rs1_rdy_i = r1;
        enq_rs2_i     = rs2;
        enq_rs2_rdy_i = r2;
        enq_div_i     = dv;
    endtask

    task automatic test_reset();
        checks++;
        if ({valid_o, data_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset_issue got valid=%b data=%h exp valid=0 data=0", valid_o, data_o);
        end
        checks++;
        if ({full_o, empty_o, enq_ready_o, count_o} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL reset_status got full=%b empty=%b rdy=%b count=%0d exp 0 1 1 0",
                     full_o, empty_o, enq_ready_o, count_o);
        end
    endtask

    task automatic test_basic();
        set_enq(6'd3, 6'd5, 1, 6'd0, 0, 0);
        tick();
        clear_inputs();
        checks++;
        if (valid_o !== 1'b1 || data_o !== {6'd0, 6'd5, 6'd3}) begin
            failures++;
            $display("FAIL basic_issue got valid=%b data=%h exp valid=1 data=%h",
                     valid_o, data_o, {6'd0, 6'd5, 6'd3});
        end
        tick();
        checks++;
        if (count_o !== 4'd0 || empty_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_drain got count=%0d empty=%b exp 0 1", count_o, empty_o);
        end
    endtask

    task automatic test_wakeup_order();
        set_enq(6'd1, 6'd9, 0, 6'd0, 0, 0);
        tick();
        set_enq(6'd2, 6'd1, 1, 6'd2, 1, 0);
        tick();
        clear_inputs();
        checks++;
        if (valid_o !== 1'b1 || data_o[5:0] !== 6'd2) begin
            failures++;
            $display("FAIL order_young_first got valid=%b rob=%0d exp valid=1 rob=2", valid_o, data_o[5:0]);
        end
        wakeup_dest_i[17:12] = 6'd9;
        wakeup_valid_i[2]    = 1;
        tick();
        clear_inputs();
        checks++;
        if (valid_o !== 1'b1 || data_o !== {6'd0, 6'd9, 6'd1}) begin
            failures++;
            $display("FAIL order_woken got valid=%b data=%h exp valid=1 data=%h",
                     valid_o, data_o, {6'd0, 6'd9, 6'd1});
        end
        tick();
    endtask

    task automatic test_full();
        int exp_rob;
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(6'(8 + i), 6'd20, 0, 6'd0, 0, 0);
            tick();
        end
        clear_inputs();
        checks++;
        if (full_o !== 1'b1 || enq_ready_o !== 1'b0 || count_o !== 4'd8) begin
            failures++;
            $display("FAIL full_flag got full=%b rdy=%b count=%0d exp 1 0 8", full_o, enq_ready_o, count_o);
        end
        wakeup_dest_i[5:0] = 6'd20;
        wakeup_valid_i[0]  = 1;
        set_enq(6'd63, 6'd0, 1, 6'd0, 1, 0);
        tick();
        clear_inputs();
        set_enq(6'd62, 6'd0, 1, 6'd0, 1, 0);
        checks++;
        if (valid_o !== 1'b1 || data_o[5:0] !== 6'd8 || count_o !== 4'd8) begin
            failures++;
            $display("FAIL full_issue got valid=%b rob=%0d count=%0d exp 1 8 8", valid_o, data_o[5:0], count_o);
        end
        tick();
        clear_inputs();
        checks++;
        if (count_o !== 4'd7 || full_o !== 1'b0) begin
            failures++;
            $display("FAIL full_reject got count=%0d full=%b exp 7 0", count_o, full_o);
        end
        exp_rob = 9;
        for (int c = 0; c < 20 && count_o != 0; c++) begin
            if (valid_o) begin
                checks++;
                if (data_o[5:0] !== 6'(exp_rob)) begin
                    failures++;
                    $display("FAIL full_drain_order got rob=%0d exp rob=%0d", data_o[5:0], exp_rob);
                end
                exp_rob++;
            end
            tick();
        end
        checks++;
        if (count_o !== 4'd0 || exp_rob != 16) begin
            failures++;
            $display("FAIL full_drain_end got count=%0d next_rob=%0d exp 0 16", count_o, exp_rob);
        end
    endtask

    task automatic test_div();
        set_enq(6'd5, 6'd0, 0, 6'd0, 0, 1);
        tick();
        set_enq(6'd6, 6'd3, 1, 6'd4, 1, 0);
        busy_i = 1;
        checks++;
        if (valid_o !== 1'b1 || data_o[5:0] !== 6'd5) begin
            failures++;
            $display("FAIL div_issue got valid=%b rob=%0d exp 1 5", valid_o, data_o[5:0]);
        end
        tick();
        set_enq(6'd7, 6'd0, 1, 6'd0, 1, 0);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (valid_o !== 1'b0) begin
                failures++;
                $display("FAIL div_busy_hold cycle=%0d got valid=%b exp 0", c, valid_o);
            end
            tick();
            clear_inputs();
        end
        busy_i = 0;
        checks++;
        if (valid_o !== 1'b0 || data_o !== 18'd0) begin
            failures++;
            $display("FAIL div_done_cycle got valid=%b data=%h exp 0 0", valid_o, data_o);
        end
        tick();
        busy_i = 1;
        checks++;
        if (valid_o !== 1'b1 || data_o[5:0] !== 6'd6) begin
            failures++;
            $display("FAIL div_resume got valid=%b rob=%0d exp 1 6", valid_o, data_o[5:0]);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o[5:0] !== 6'd7) begin
            failures++;
            $display("FAIL div_resume2 got valid=%b rob=%0d exp 1 7", valid_o, data_o[5:0]);
        end
        tick();
        busy_i = 0;
    endtask

    task automatic test_enq_wakeup();
        set_enq(6'd4, 6'd0, 0, 6'd12, 0, 0);
        wakeup_dest_i[11:6] = 6'd12;
        wakeup_valid_i[1]   = 1;
        tick();
        clear_inputs();
        checks++;
        if (valid_o !== 1'b1 || data_o !== {6'd12, 6'd0, 6'd4}) begin
            failures++;
            $display("FAIL enq_wakeup got valid=%b data=%h exp 1 %h", valid_o, data_o, {6'd12, 6'd0, 6'd4});
        end
        tick();
    endtask

    task automatic test_flush();
        busy_i = 1;
        set_enq(6'd10, 6'd0, 1, 6'd0, 1, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_enq(6'(40 + i), 6'd30, 0, 6'd0, 0, 0);
            tick();
        end
        clear_inputs();
        checks++;
        if (count_o !== 4'd5 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_setup got count=%0d valid=%b exp 5 0", count_o, valid_o);
        end
        core_flush_i = 1;
        set_enq(6'd11, 6'd0, 1, 6'd0, 1, 0);
        tick();
        clear_inputs();
        checks++;
        if (count_o !== 4'd0 || empty_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got count=%0d empty=%b valid=%b exp 0 1 0", count_o, empty_o, valid_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (valid_o !== 1'b0) begin
                failures++;
                $display("FAIL flush_quiet cycle=%0d got valid=%b exp 0", c, valid_o);
            end
        end
        set_enq(6'd12, 6'd0, 1, 6'd0, 1, 0);
        tick();
        clear_inputs();
        checks++;
        if (valid_o !== 1'b1 || data_o[5:0] !== 6'd12) begin
            failures++;
            $display("FAIL flush_state_issue got valid=%b rob=%0d exp 1 12", valid_o, data_o[5:0]);
        end
        tick();
        busy_i = 0;
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            if ($urandom_range(99) < 60)
                set_enq(6'($urandom_range(63)), 6'($urandom_range(7)), bit'($urandom_range(1)),
                        6'($urandom_range(7)), bit'($urandom_range(1)), $urandom_range(99) < 15);
            for (int k = 0; k < NW; k++) begin
                wakeup_valid_i[k]       = ($urandom_range(99) < 30);
                wakeup_dest_i[6*k +: 6] = 6'($urandom_range(7));
            end
            busy_i       = bit'($urandom_range(1));
            core_flush_i = ($urandom_range(99) < 2);
            model_outs();
            n = mq.size();
            checks++;
            if (valid_o !== exp_valid) begin
                failures++;
                $display("FAIL rand_valid cycle=%0d got %b exp %b", c, valid_o, exp_valid);
            end
            checks++;
            if (data_o !== exp_data) begin
                failures++;
                $display("FAIL rand_data cycle=%0d got %h exp %h", c, data_o, exp_data);
            end
            checks++;
            if (count_o !== 4'(n)) begin
                failures++;
                $display("FAIL rand_count cycle=%0d got %0d exp %0d", c, count_o, n);
            end
            checks++;
            if ({full_o, empty_o, enq_ready_o} !== {n == DEPTH, n == 0, n != DEPTH}) begin
                failures++;
                $display("FAIL rand_status cycle=%0d got full=%b empty=%b rdy=%b count_exp=%0d",
                         c, full_o, empty_o, enq_ready_o, n);
            end
            tick();
        end
        clear_inputs();
        busy_i = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        busy_i       = 0;
        core_reset_i = 1;
        mq.delete();
        m_div = 0;
        repeat (2) @(posedge core_clock_i);
        #1;
        core_reset_i = 0;
        test_reset();
        test_basic();
        test_wakeup_order();
        test_full();
        test_div();
        test_enq_wakeup();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
